// File: rtl/gpio_input_irq_pkg.sv
// Shared definitions for the GPIO input conditioning block: register map and
// the debounce counter sizing helper.
package gpio_input_irq_pkg;

  typedef enum logic [1:0] {
    REG_STATE   = 2'b00,
    REG_RISE_EN = 2'b01,
    REG_FALL_EN = 2'b10,
    REG_PENDING = 2'b11
  } reg_sel_e;

  localparam int DATA_W = 32;

  // Counter wide enough to hold DEBOUNCE_CYCLES-1 with one bit of headroom.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/gpio_input_irq_debounce.sv
// Single-pin conditioner: multi-flop synchroniser followed by a stability
// counter that only lets the clean level follow after a full quiet window.
module gpio_input_irq_debounce
  import gpio_input_irq_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_in,
  output logic clean
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0] chain;
  logic [CW-1:0]          count;
  logic                   sync;

  assign sync = chain[SYNC_STAGES-1];

  // Synchroniser shift chain
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pin_in};
    end
  end

  // Stability counter; any return to the clean level restarts the window
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      clean <= 1'b0;
    end else if (sync == clean) begin
      count <= '0;
    end else if (count == CNT_LAST) begin
      clean <= sync;
      count <= '0;
    end else begin
      count <= count + CNT_ONE;
    end
  end

endmodule

// File: rtl/gpio_input_irq.sv
// GPIO input conditioning: per-pin debounce, enabled edge detection into sticky
// write-1-to-clear pending flags, one level interrupt and a register read mux.
module gpio_input_irq
  import gpio_input_irq_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  pins_in,
  input  logic [1:0]        reg_sel,
  input  logic              we,
  input  logic [DATA_W-1:0] di,
  output logic [DATA_W-1:0] dout,
  output logic [WIDTH-1:0]  pins_clean,
  output logic              irq
);

  logic [WIDTH-1:0] clean_d;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] w1c_mask;
  logic [WIDTH-1:0] wr_data;
  logic             wr_rise;
  logic             wr_fall;
  logic             wr_pend;
  logic             unused_di;

  for (genvar g = 0; g < WIDTH; g++) begin : g_pin
    gpio_input_irq_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .pin_in (pins_in[g]),
      .clean  (pins_clean[g])
    );
  end

  assign wr_data   = di[WIDTH-1:0];
  assign unused_di = ^di;
  assign wr_rise   = we && (reg_sel == REG_RISE_EN);
  assign wr_fall   = we && (reg_sel == REG_FALL_EN);
  assign wr_pend   = we && (reg_sel == REG_PENDING);

  // Disabled edges vanish here; they are never remembered for a later enable.
  assign edge_set = (pins_clean & ~clean_d & rise_en) |
                    (~pins_clean & clean_d & fall_en);
  assign w1c_mask = wr_pend ? wr_data : {WIDTH{1'b0}};

  // Delayed clean level for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      clean_d <= '0;
    end else begin
      clean_d <= pins_clean;
    end
  end

  // Edge enable registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rise_en <= '0;
      fall_en <= '0;
    end else begin
      if (wr_rise) begin
        rise_en <= wr_data;
      end
      if (wr_fall) begin
        fall_en <= wr_data;
      end
    end
  end

  // Sticky pending flags; a new edge beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~w1c_mask) | edge_set;
    end
  end

  assign irq = |pending;

  // Register read mux, upper bits read as zero
  always_comb begin
    dout = '0;
    case (reg_sel)
      REG_STATE:   dout[WIDTH-1:0] = pins_clean;
      REG_RISE_EN: dout[WIDTH-1:0] = rise_en;
      REG_FALL_EN: dout[WIDTH-1:0] = fall_en;
      REG_PENDING: dout[WIDTH-1:0] = pending;
      default:     dout = '0;
    endcase
  end

endmodule

// File: tb/tb_gpio_input_irq.sv
// Self-checking bench for gpio_input_irq: directed scenarios plus random pin and
// register traffic, checked every cycle against a sample-window reference model.
module tb_gpio_input_irq;

  localparam int W    = 16;
  localparam int SYNC = 2;
  localparam int DC   = 4;
  localparam int HL   = SYNC + DC - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  pins_in;
  logic [1:0]    reg_sel;
  logic          we;
  logic [31:0]   di;
  logic [31:0]   dout;
  logic [W-1:0]  pins_clean;
  logic          irq;

  int compared   = 0;
  int mismatched = 0;
  logic model_valid = 1'b0;

  gpio_input_irq #(.WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC)) dut (
    .clk        (clk),
    .reset      (reset),
    .pins_in    (pins_in),
    .reg_sel    (reg_sel),
    .we         (we),
    .di         (di),
    .dout       (dout),
    .pins_clean (pins_clean),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Reference model: ph[j] holds the pad value sampled j+1 edges ago.
  logic [W-1:0] ph [0:HL-1];
  logic [W-1:0] m_clean, m_cd, m_rise, m_fall, m_pend;

  always @(posedge clk) begin : model
    logic [W-1:0] flip;
    logic [W-1:0] evt;
    logic [W-1:0] clr;
    model_valid <= 1'b1;
    if (reset) begin
      for (int j = 0; j < HL; j++) ph[j] <= '0;
      m_clean <= '0; m_cd <= '0; m_rise <= '0; m_fall <= '0; m_pend <= '0;
    end else begin
      // A bit flips once the last DC synchronised samples all disagree with it.
      flip = '1;
      for (int j = SYNC - 1; j < HL; j++) flip = flip & (ph[j] ^ m_clean);
      evt = (m_clean & ~m_cd & m_rise) | (~m_clean & m_cd & m_fall);
      clr = (we && reg_sel == 2'd3) ? di[W-1:0] : '0;
      m_pend <= (m_pend & ~clr) | evt;
      if (we && reg_sel == 2'd1) m_rise <= di[W-1:0];
      if (we && reg_sel == 2'd2) m_fall <= di[W-1:0];
      m_cd    <= m_clean;
      m_clean <= m_clean ^ flip;
      ph[0] <= pins_in;
      for (int j = 1; j < HL; j++) ph[j] <= ph[j-1];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] sel);
    case (sel)
      2'd0:    return {16'h0, m_clean};
      2'd1:    return {16'h0, m_rise};
      2'd2:    return {16'h0, m_fall};
      default: return {16'h0, m_pend};
    endcase
  endfunction

  // Continuous comparison against the model
  always @(negedge clk) begin
    if (model_valid) begin
      chk("cyc_pins_clean", {16'h0, pins_clean}, {16'h0, m_clean});
      chk("cyc_irq", {31'h0, irq}, {31'h0, |m_pend});
      chk("cyc_dout", dout, model_read(reg_sel));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] sel, input logic [31:0] data);
    reg_sel = sel; di = data; we = 1'b1;
    step(1);
    we = 1'b0; di = '0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] sel, input logic [31:0] exp);
    reg_sel = sel;
    #1;
    chk(name, dout, exp);
  endtask

  initial begin
    reset = 1'b1; pins_in = 16'hFFFF; reg_sel = 2'd0; we = 1'b0; di = '0;

    // 1: reset state and release latency
    step(3);
    chk("rst_pins_clean", {16'h0, pins_clean}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    for (int s = 0; s < 4; s++) rd_chk("rst_dout", 2'(s), 32'h0);
    reg_sel = 2'd0;
    reset = 1'b0;
    step(5);
    chk("rel_early", {16'h0, pins_clean}, 32'h0);
    step(1);
    chk("rel_6cyc", {16'h0, pins_clean}, 32'h0000_FFFF);

    // 2: glitch filter
    pins_in = 16'h0000;
    step(8);
    wr(2'd1, 32'h0000_0001);
    pins_in[0] = 1'b1; step(3); pins_in[0] = 1'b0;
    step(10);
    chk("glitch3_clean", {31'h0, pins_clean[0]}, 32'h0);
    rd_chk("glitch3_pend", 2'd3, 32'h0);
    pins_in[0] = 1'b1; step(4); pins_in[0] = 1'b0;
    step(2);
    chk("pulse4_clean", {31'h0, pins_clean[0]}, 32'h1);
    step(1);
    rd_chk("pulse4_pend", 2'd3, 32'h0000_0001);
    chk("pulse4_irq", {31'h0, irq}, 32'h1);
    wr(2'd3, 32'h0000_0001);
    chk("clr_irq", {31'h0, irq}, 32'h0);
    step(6);

    // 3: masking
    wr(2'd1, 32'h0);
    wr(2'd2, 32'h0000_0100);
    pins_in[8] = 1'b1; step(10);
    rd_chk("mask_rise8", 2'd3, 32'h0);
    pins_in[8] = 1'b0; step(10);
    rd_chk("mask_fall8", 2'd3, 32'h0000_0100);
    pins_in[9] = 1'b1; step(10); pins_in[9] = 1'b0; step(10);
    rd_chk("mask_pin9", 2'd3, 32'h0000_0100);
    wr(2'd3, 32'hFFFF_FFFF);

    // 4: W1C racing a new edge
    wr(2'd2, 32'h0);
    wr(2'd1, 32'h0000_0008);
    pins_in[3] = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (pins_clean[3]) break;
      step(1);
    end
    chk("race_wait_clean3", {31'h0, pins_clean[3]}, 32'h1);
    wr(2'd3, 32'h0000_0008);
    rd_chk("race_set_wins", 2'd3, 32'h0000_0008);
    chk("race_irq", {31'h0, irq}, 32'h1);
    wr(2'd3, 32'h0000_0008);
    rd_chk("race_cleared", 2'd3, 32'h0);
    chk("race_irq_low", {31'h0, irq}, 32'h0);
    pins_in[3] = 1'b0; step(10);

    // 5: read-only STATE and unused upper bits
    wr(2'd0, 32'hFFFF_FFFF);
    rd_chk("state_ro", 2'd0, 32'h0);
    wr(2'd1, 32'hFFFF_FFFF);
    rd_chk("rise_en_width", 2'd1, 32'h0000_FFFF);
    wr(2'd1, 32'h0);

    // 6: reset mid-debounce
    pins_in[5] = 1'b1;
    step(5);
    reset = 1'b1; step(1); reset = 1'b0;
    chk("mid_rst_clean5", {31'h0, pins_clean[5]}, 32'h0);
    step(5);
    chk("mid_rst_early", {31'h0, pins_clean[5]}, 32'h0);
    step(1);
    chk("mid_rst_6cyc", {31'h0, pins_clean[5]}, 32'h1);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) pins_in = pins_in ^ W'(1 << $urandom_range(0, W - 1));
      reg_sel = 2'($urandom_range(0, 3));
      we = ($urandom_range(0, 7) == 0);
      di = $urandom;
      if ($urandom_range(0, 499) == 0) reset = 1'b1;
      step(1);
      reset = 1'b0;
    end
    we = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
